pool2d_stream: RTL

Parametrised 2x2/stride-2 pooling stage for the conv feature path, the next generation of the fixed 6-channel/28-column max pool. It accepts one pixel per cycle, carrying all channels in parallel in raster order, from the conv stage. It supports max or average mode and buffers pooled vectors in a small FIFO. It serialises them one channel per cycle toward post-processing with a full ready/valid handshake on both sides.

---
 rtl/pool2d_stream.sv | 103 ++++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2/stride-2 max/avg pooling of raster pixels (i_valid/i_features/o_ready in), FIFO-buffered, serialised one channel per beat (o_valid/o_feature/o_channel/o_last out, i_ready back-pressure)
module pool2d_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHANNELS = 6,
  parameter int NUM_COLUMNS = 28,
  parameter int NUM_ROWS = 28,
  parameter int MODE = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] i_features,
  output logic                                   o_ready,
  output logic                                   o_valid,
  output logic signed [DATA_WIDTH-1:0]           o_feature,
  output logic [CW-1:0]                          o_channel,
  output logic                                   o_last,
  input  logic                                   i_ready
);
  localparam int PW = DATA_WIDTH + 1;
  localparam int XW = NUM_COLUMNS > 1 ? $clog2(NUM_COLUMNS) : 1;
  localparam int YW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
  localparam int HW = NUM_COLUMNS > 2 ? $clog2(NUM_COLUMNS / 2) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  typedef logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef logic [NUM_CHANNELS-1:0][PW-1:0] pvec_t;
  if (NUM_COLUMNS % 2 != 0 || NUM_ROWS % 2 != 0 || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("pool2d_stream: NUM_COLUMNS and NUM_ROWS must be even and FIFO_DEPTH >= 2");
  end
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [HW-1:0] half;
  vec_t hold, quad, head;
  pvec_t pair;
  pvec_t lb [NUM_COLUMNS/2];
  vec_t mem [FIFO_DEPTH];
  logic mem_last [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, count_next;
  logic [CW-1:0] ch;
  logic accept, push, pop, col_end, row_end, frame_end, ch_end;
  assign accept = i_valid && o_ready;
  assign col_end = col == XW'(NUM_COLUMNS - 1);
  assign row_end = row == YW'(NUM_ROWS - 1);
  assign frame_end = col_end && row_end;
  assign half = HW'(col >> 1);
  assign push = accept && col[0] && row[0];
  assign ch_end = ch == CW'(NUM_CHANNELS - 1);
  assign pop = o_valid && i_ready && ch_end;
  assign count_next = count + NW'(push) - NW'(pop);
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] a, b;
    logic signed [PW-1:0] p, l;
    logic signed [PW:0] s;
    assign a = hold[c];
    assign b = i_features[c];
    assign l = lb[half][c];
    assign p = MODE != 0 ? PW'(a) + PW'(b) : (a > b ? PW'(a) : PW'(b));
    assign s = (PW + 1)'(p) + (PW + 1)'(l);
    assign pair[c] = p;
    assign quad[c] = MODE != 0 ? s[PW:2] : (p > l ? p[DATA_WIDTH-1:0] : l[DATA_WIDTH-1:0]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_end ? '0 : col + 1'b1;
      if (col_end) row <= row_end ? '0 : row + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (accept && !col[0]) hold <= i_features;
    if (accept && col[0] && !row[0]) lb[half] <= pair;
    if (push) begin
      mem[wr_ptr] <= quad;
      mem_last[wr_ptr] <= frame_end;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ch <= '0;
      o_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr == FW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == FW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (o_valid && i_ready) ch <= ch_end ? '0 : ch + 1'b1;
      count <= count_next;
      o_ready <= count_next < NW'(FIFO_DEPTH);
    end
  end
  assign head = mem[rd_ptr];
  assign o_valid = count != '0;
  assign o_channel = ch;
  assign o_feature = o_valid ? head[ch] : '0;
  assign o_last = o_valid && ch_end && mem_last[rd_ptr];
endmodule
